// File: rtl/clint.sv
`default_nettype none
// ============================================================================
// Module      : clint
// Description : Core-local interruptor. Holds the free-running mtime counter,
//               the mtimecmp compare register and the msip software-interrupt
//               bit behind a single-outstanding request/response port, and
//               drives msip/mtip into the CSR file.
//
//               Ports
//                 clk, rst          clock, synchronous active-high reset
//                 req_*             request channel (valid/ready handshake)
//                 resp_*            response channel (valid/ready handshake)
//                 msip, mtip        interrupt-pending outputs
//
//               Register map (offset from BASE_ADDR, 64 KiB window)
//                 0x0000 msip (bit 0), 0x4000 mtimecmp, 0xBFF8 mtime
// Revision    : 1.0 - initial release
// ============================================================================
module clint #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        msip,
    output logic        mtip
);

    // Prescaler needs at least one bit even when TICK_DIV is 1.
    localparam int              c_PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX  = c_PW'(TICK_DIV - 1);

    localparam logic [15:0]     c_OFF_MSIP     = 16'h0000;
    localparam logic [15:0]     c_OFF_MTIMECMP = 16'h4000;
    localparam logic [15:0]     c_OFF_MTIME    = 16'hBFF8;

    localparam logic [0:0]      c_IDLE = 1'b0;
    localparam logic [0:0]      c_RESP = 1'b1;

    logic [0:0]      r_state;
    logic [63:0]     r_mtime;
    logic [63:0]     r_mtimecmp;
    logic            r_msip;
    logic [c_PW-1:0] r_presc;
    logic [63:0]     r_rdata;
    logic            r_err;

    logic [63:0]     w_off;
    logic            w_in_win;
    logic            w_hit_msip;
    logic            w_hit_mtimecmp;
    logic            w_hit_mtime;
    logic            w_mapped;
    logic            w_accept;
    logic            w_tick;
    logic [63:0]     w_wmask;
    logic [63:0]     w_rd_mux;

    // Address decode. When req_addr >= BASE_ADDR the subtraction cannot wrap,
    // so the window test reduces to the upper offset bits being zero.
    assign w_off          = req_addr - BASE_ADDR;
    assign w_in_win       = (req_addr >= BASE_ADDR) && (w_off[63:16] == 48'd0);
    assign w_hit_msip     = w_in_win && (w_off[15:0] == c_OFF_MSIP);
    assign w_hit_mtimecmp = w_in_win && (w_off[15:0] == c_OFF_MTIMECMP);
    assign w_hit_mtime    = w_in_win && (w_off[15:0] == c_OFF_MTIME);
    assign w_mapped       = w_hit_msip || w_hit_mtimecmp || w_hit_mtime;

    assign req_ready = (r_state == c_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_tick    = (r_presc == c_PRESC_MAX);

    // Expand byte strobes into a bit mask for the byte-wise merges below.
    generate
        for (genvar i = 0; i < 8; i++) begin : g_wmask
            assign w_wmask[8*i +: 8] = {8{req_wstrb[i]}};
        end
    endgenerate

    // Read data is taken from the pre-edge register values.
    always_comb begin
        w_rd_mux = 64'd0;
        if (w_hit_msip) begin
            w_rd_mux = {63'd0, r_msip};
        end else if (w_hit_mtimecmp) begin
            w_rd_mux = r_mtimecmp;
        end else if (w_hit_mtime) begin
            w_rd_mux = r_mtime;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_mtime    <= 64'd0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_msip     <= 1'b0;
            r_presc    <= '0;
            r_rdata    <= 64'd0;
            r_err      <= 1'b0;
        end else begin
            // Timer: a software write to mtime wins over the tick and
            // restarts the prescaler so the new value gets a full period.
            if (w_accept && req_wen && w_hit_mtime) begin
                r_mtime <= (r_mtime & ~w_wmask) | (req_wdata & w_wmask);
                r_presc <= '0;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_accept && req_wen && w_hit_mtimecmp) begin
                r_mtimecmp <= (r_mtimecmp & ~w_wmask) | (req_wdata & w_wmask);
            end

            if (w_accept && req_wen && w_hit_msip && req_wstrb[0]) begin
                r_msip <= req_wdata[0];
            end

            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_rdata <= req_wen ? 64'd0 : w_rd_mux;
                        r_err   <= !w_mapped;
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (resp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign resp_valid = (r_state == c_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign msip       = r_msip;
    assign mtip       = (r_mtime >= r_mtimecmp);

endmodule
`default_nettype wire

// File: doc/clint.md
Name: clint

Overview:
Core-local interruptor. Memory-mapped on the data bus; sits directly upstream of the CSR file and drives its msip/mtip inputs. Holds the free-running mtime counter, the mtimecmp compare register and the msip software-interrupt bit. Exposes them through a single-outstanding request/response port.

Parameters:
BASE_ADDR, 64'h0000_0000_0200_0000, base of the 64 KiB CLINT window
TICK_DIV, 1, clk cycles per mtime increment; must be >=1; 1 means increment every cycle

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when valid&ready
req_wen  input  1  1=write, 0=read
req_addr  input  64  byte address, 8-byte aligned
req_wdata  input  64  write data
req_wstrb  input  8  byte enables for write
resp_valid  output  1  response present
resp_ready  input  1  response consumed when valid&ready
resp_rdata  output  64  read data (0 for writes/errors)
resp_err  output  1  unmapped address
msip  output  1  software interrupt pending, to CSR file
mtip  output  1  timer interrupt pending, to CSR file

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Register map (offset = req_addr - BASE_ADDR): 0x0000 msip (bit 0 only; other bits read 0, writes ignored); 0x4000 mtimecmp; 0xBFF8 mtime.
- Any other offset, or any address outside [BASE_ADDR, BASE_ADDR+0xFFFF], is unmapped: resp_err=1, resp_rdata=0, no state change.
- Reset: mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip reg=0, FSM=IDLE, resp_valid=0, resp_rdata=0, resp_err=0. Outputs after reset: req_ready=1, msip=0, mtip=0.
- FSM has two states.
  - IDLE: req_ready=1. On req_valid, accept; go to RESP.
  - RESP: req_ready=0, resp_valid=1. resp_rdata and resp_err are held stable. On resp_ready, return to IDLE; a new request is accepted no earlier than the following cycle.
- Latency: response appears the cycle after acceptance. At most one request is outstanding.
- Reads: resp_rdata is captured at the acceptance edge from pre-edge register values. An mtime read returns the value before that edge's increment.
- Writes:
  - Committed at the acceptance edge, byte-wise per req_wstrb; wstrb=0 is a no-op write that still responds.
  - A write to mtime overrides the same-edge increment and clears the prescaler; the written value then counts normally.
  - A write to mtimecmp takes effect for the compare on the next cycle.
- Timer:
  - prescaler counts 0..TICK_DIV-1.
  - mtime increments by 1 when prescaler==TICK_DIV-1, then prescaler wraps to 0.
  - mtime wraps 2^64-1 -> 0 silently.
- mtip = (mtime >= mtimecmp), unsigned 64-bit compare on current register values (combinational from registers). It stays asserted until mtimecmp is raised or mtime is written lower.
- msip output = msip reg bit 0.
- Reset asserted mid-transaction drops any pending response: resp_valid=0 on the next cycle and no partial write survives.
- Requests in RESP are not accepted (req_ready=0); the requester must hold req_valid and payload until accepted.

Test Plan:
- Reset then idle 10 cycles, TICK_DIV=1: mtime read returns 9 or 10 depending on acceptance cycle (exact: value at acceptance edge); msip=0, mtip=0, resp_err=0.
- Write mtimecmp=20 with wstrb=8'hFF, then poll: mtip rises on the first cycle mtime==20; write mtimecmp=64'hFFFF_FFFF_FFFF_FFFF -> mtip=0 next cycle.
- Write msip=64'hFFFF_FFFF_FFFF_FFFF -> msip=1, read back 64'h1. Write 0 -> msip=0.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFE during counting -> next reads follow ...FFFF then 0 (wrap). Partial write wstrb=8'h01, data 0xAA to mtimecmp from reset value -> read 64'hFFFF_FFFF_FFFF_FFAA.
- Read offset 0x1000 -> resp_err=1, rdata=0, no register changed. Hold resp_ready=0 for 5 cycles -> resp_valid, rdata stable and req_ready=0 throughout.
- TICK_DIV=4: mtime increments exactly every 4 cycles. Assert rst while in RESP -> resp_valid=0, mtime=0, mtimecmp all-ones next cycle.
